alu_seq_core: RTL

- Clocked, handshaked ALU that executes the team's 4-bit select / carry-in operation set.
- Sits between a request source (bench driver or sequencer) and a response sink.
- Accepts one operation per transaction through a valid/ready request port and returns the result on a valid/ready response port.
- Most operations take one cycle. Shifts are iterative, one bit position per cycle.

---
 rtl/alu_seq_core_if.sv | 30 +++
 rtl/alu_seq_core.sv | 130 +++++++++++++
 2 files changed

// File: rtl/alu_seq_core_if.sv
// Request/response bundle for alu_seq_core: valid/ready request carrying operands,
// valid/ready response carrying the result, flags and completed-operation count.
interface alu_seq_core_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SEL_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [SEL_W-1:0] select;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] y;
  logic             c_out;
  logic             illegal;
  logic [CNT_W-1:0] op_count;

  modport master (
    output req_valid, a, b, c_in, select, rsp_ready,
    input  req_ready, rsp_valid, y, c_out, illegal, op_count
  );

  modport slave (
    input  req_valid, a, b, c_in, select, rsp_ready,
    output req_ready, rsp_valid, y, c_out, illegal, op_count
  );
endinterface

// File: rtl/alu_seq_core.sv
// Handshaked ALU: single-cycle arithmetic/logic ops, iterative one-bit-per-cycle shifts,
// result held until the sink takes it, plus a wrapping count of completed responses.
module alu_seq_core #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SEL_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic           i_clk,
  input logic           i_rst_n,
  alu_seq_core_if.slave bus
);
  localparam int unsigned ShW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StExec, StShift, StResp} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_y, w_y_nxt, w_y_alu;
  logic             r_cin, r_cout, r_ill, w_cout_nxt, w_ill_nxt, w_cout_alu, w_ill_alu;
  logic [SEL_W-1:0] r_sel;
  logic [ShW-1:0]   r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_ops;
  logic             w_accept, w_is_shift, w_rsp_hs;
  logic [WIDTH:0]   w_sum, w_a_ext, w_b_ext, w_nb_ext, w_cin_ext, w_ones_ext;

  assign w_accept   = bus.req_valid && (r_state == StIdle);
  assign w_is_shift = (bus.select == SEL_W'(7));
  assign w_rsp_hs   = (r_state == StResp) && bus.rsp_ready;

  assign w_a_ext    = {1'b0, r_a};
  assign w_b_ext    = {1'b0, r_b};
  assign w_nb_ext   = {1'b0, ~r_b};
  assign w_cin_ext  = {{WIDTH{1'b0}}, r_cin};
  assign w_ones_ext = {1'b0, {WIDTH{1'b1}}};

  // Arithmetic is done at WIDTH+1 bits so the top bit is the carry out.
  always_comb begin
    w_sum      = '0;
    w_y_alu    = '0;
    w_cout_alu = 1'b0;
    w_ill_alu  = 1'b0;
    case (r_sel)
      SEL_W'(0): w_sum = w_a_ext + w_cin_ext;
      SEL_W'(1): w_sum = w_a_ext + w_b_ext + w_cin_ext;
      SEL_W'(2): w_sum = w_a_ext + w_nb_ext + w_cin_ext;
      SEL_W'(3): w_sum = r_cin ? w_b_ext : (w_a_ext + w_ones_ext);
      SEL_W'(4): w_y_alu = r_a & r_b;
      SEL_W'(5): w_y_alu = r_cin ? (r_a ^ r_b) : (r_a | r_b);
      SEL_W'(6): w_y_alu = ~r_a;
      SEL_W'(8): w_y_alu = '0;
      default:   w_ill_alu = 1'b1;
    endcase
    if (r_sel <= SEL_W'(3)) begin
      w_y_alu    = w_sum[WIDTH-1:0];
      w_cout_alu = w_sum[WIDTH];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_cout_nxt  = r_cout;
    w_ill_nxt   = r_ill;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          // Shifts work in place on r_y, so preload it with the operand.
          w_y_nxt     = bus.a;
          w_cout_nxt  = 1'b0;
          w_ill_nxt   = 1'b0;
          w_cnt_nxt   = bus.b[ShW-1:0];
          w_state_nxt = w_is_shift ? StShift : StExec;
        end
      end
      StExec: begin
        w_y_nxt     = w_y_alu;
        w_cout_nxt  = w_cout_alu;
        w_ill_nxt   = w_ill_alu;
        w_state_nxt = StResp;
      end
      StShift: begin
        if (r_cnt == '0) begin
          w_state_nxt = StResp;
        end else begin
          w_y_nxt   = r_cin ? (r_y >> 1) : (r_y << 1);
          w_cnt_nxt = r_cnt - ShW'(1);
        end
      end
      StResp: begin
        if (bus.rsp_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_sel   <= '0;
      r_y     <= '0;
      r_cout  <= 1'b0;
      r_ill   <= 1'b0;
      r_cnt   <= '0;
      r_ops   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_y     <= w_y_nxt;
      r_cout  <= w_cout_nxt;
      r_ill   <= w_ill_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_cin <= bus.c_in;
        r_sel <= bus.select;
      end
      if (w_rsp_hs) r_ops <= r_ops + CNT_W'(1);
    end
  end

  assign bus.req_ready = (r_state == StIdle);
  assign bus.rsp_valid = (r_state == StResp);
  assign bus.y         = r_y;
  assign bus.c_out     = r_cout;
  assign bus.illegal   = r_ill;
  assign bus.op_count  = r_ops;
endmodule
